immed_gen: RTL and testbench
============================

Name: immed_gen

Overview:
- Decode-stage immediate generator for the pipelined RV32I core.
- Extracts and sign-extends the immediate from a 32-bit instruction word, selected by the decoder's 4-bit instruction-type code.
- Provides a combinational result for the decode stage, plus a registered copy with a stall enable for the ID/EX pipeline register.

Parameters:
- XLEN, 32, data and instruction width; only 32 is supported.

Ports:
- clk  input  1  pipeline clock; the registered copy updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  capture enable for immed_q; 0 means stall and hold.
- instType  input  4  instruction class code, listed under Behaviour.
- inst  input  32  raw instruction word.
- immed  output  32  combinational immediate.
- immed_q  output  32  immed registered through the ID/EX stage.

Behaviour:
- instType codes: 0 load, 1 imm-ALU, 2 store, 3 reg, 4 lui, 5 auipc, 6 branch, 7 jalr, 8 jal.
- immed is purely combinational, with zero latency from inst/instType. It must settle without any clock edge.
- I-type (codes 0, 1, 7): immed = sign-extended inst[31:20].
- S-type (code 2): immed = sign-extended {inst[31:25], inst[11:7]}.
- B-type (code 6): immed = sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
- U-type (codes 4, 5): immed = {inst[31:12], 12'b0}. No further sign extension; bit 31 comes from inst[31].
- J-type (code 8): immed = sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
- Sign bit is always inst[31] for every type except reg.
- Code 3 (reg) and unused codes 9-15: immed is driven all-X (32'bx) as a deliberate don't-care. The bench checks this with case equality.
- Shift-immediate ALU ops (slli/srli/srai) use code 1. immed then carries inst[31:20] as-is; shamt and funct7 interpretation is the ALU's job.
- immed_q: async reset to 32'h0 while rst_n is low. Reset assertion mid-cycle clears it immediately.
- After reset release, on each rising clk edge: if en = 1, immed_q <= immed; if en = 0, immed_q holds.
- An X value on immed (reg type) propagates into immed_q unchanged. No X-scrubbing is applied.
- inst/instType changes between clock edges affect only immed, never immed_q.

Decomposition:
- Shared package (riscv_pkg):
  - inst_type_t enum with the 9 codes above, in a 4-bit encoding.
  - localparams for the opcode fields.
- One natural sub-module: immed_decode (purely combinational mux plus sign extension).
- immed_gen wraps immed_decode and adds the enable flop.

Test Plan:
- Hold rst_n=0, set inst=32'h07b20193 (addi x3,x4,123) with instType=1 -> immed_q==0 while reset is held.
- After reset, run these without any clock:
  - lui 32'h030391b7, type 4 -> immed==50565120 (0x03039000).
  - jal 32'h038031ef, type 8 -> immed==12344.
  - beq x3,x4,128 32'h08418063, type 6 -> immed==128.
  - sb 32'h08320023, type 2 -> immed==128.
  - lb 32'h08020183, type 0 -> immed==128.
  - addi 32'h07b20193, type 1 -> immed==123.
  - add 32'h005201b3, type 3 -> immed===32'bx.
- Negative values:
  - addi x3,x4,-1 32'hfff20193, type 1 -> immed==32'hFFFFFFFF.
  - beq x3,x4,-4 32'hFE418EE3, type 6 -> immed==32'hFFFFFFFC.
- Register path:
  - Apply addi 123 with en=1 and clock once -> immed_q==123.
  - Set en=0, change to lui 12345 and clock -> immed_q stays 123.
  - Set en=1 and clock -> immed_q==50565120.
- Async reset mid-operation: with immed_q==123, drop rst_n between edges -> immed_q==0 immediately, before the next clk edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: instruction-class codes and opcode fields.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    IT_LOAD   = 4'd0,
    IT_IMM    = 4'd1,
    IT_STORE  = 4'd2,
    IT_REG    = 4'd3,
    IT_LUI    = 4'd4,
    IT_AUIPC  = 4'd5,
    IT_BRANCH = 4'd6,
    IT_JALR   = 4'd7,
    IT_JAL    = 4'd8
  } inst_type_t;

  // Major opcode field inst[6:0].
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/immed_decode.sv
// Combinational immediate extraction and sign extension for RV32I formats.
module immed_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      instType,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] immed
);

  logic sgn;
  assign sgn = inst[31];

  always_comb begin
    immed = 'x;
    case (instType)
      IT_LOAD, IT_IMM, IT_JALR:
        immed = {{20{sgn}}, inst[31:20]};
      IT_STORE:
        immed = {{20{sgn}}, inst[31:25], inst[11:7]};
      IT_BRANCH:
        immed = {{19{sgn}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IT_LUI, IT_AUIPC:
        immed = {inst[31:12], 12'b0};
      IT_JAL:
        immed = {{11{sgn}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      // reg type and unused codes carry no immediate
      default:
        immed = 'x;
    endcase
  end

endmodule

// File: rtl/immed_gen.sv
// Decode-stage immediate generator with an ID/EX stall-enabled register copy.
module immed_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [3:0]      instType,
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] immed,
  output logic [XLEN-1:0] immed_q
);

  immed_decode #(.XLEN(XLEN)) u_dec (
    .instType (instType),
    .inst     (inst),
    .immed    (immed)
  );

  // X from a reg-type decode is passed through untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  immed_q <= '0;
    else if (en) immed_q <= immed;
  end

endmodule

// File: tb/tb_immed_gen.sv
// Scoreboard bench for immed_gen: directed vectors, queued expectations.
module tb_immed_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  instType = 4'd0;
  logic [31:0] inst = 32'h0;
  logic [31:0] immed, immed_q;

  immed_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .instType (instType),
    .inst     (inst),
    .immed    (immed),
    .immed_q  (immed_q)
  );

  typedef struct {
    string       name;
    bit          use_q;
    logic [31:0] exp;
  } exp_t;

  exp_t  sb[$];
  event  chk_ev;
  int    total = 0;
  int    bad = 0;
  logic [31:0] xval;

  // Monitor: pops one expectation each time the stimulus presents a sample point.
  initial begin
    forever begin
      @(chk_ev);
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL sample_without_expectation");
      end else begin
        exp_t e;
        logic [31:0] got;
        e = sb.pop_front();
        got = e.use_q ? immed_q : immed;
        total++;
        if (got !== e.exp) begin
          bad++;
          $display("FAIL %s got=%h exp=%h", e.name, got, e.exp);
        end
      end
    end
  end

  task automatic expect_out(input string name, input bit use_q, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.use_q = use_q; e.exp = exp;
    sb.push_back(e);
    #1 -> chk_ev;
    #1;
  endtask

  task automatic apply(input logic [31:0] i, input logic [3:0] t);
    inst = i; instType = t;
    #1;
  endtask

  task automatic tick();
    #4 clk = 1'b1;
    #5 clk = 1'b0;
    #1;
  endtask

  initial begin
    xval = 32'bx;

    // Reset held: register must read zero regardless of the instruction.
    rst_n = 1'b0; en = 1'b1;
    apply(32'h07b20193, 4'd1);
    tick();
    expect_out("reset_q", 1'b1, 32'h0);
    #3 rst_n = 1'b1;
    #2;

    // Combinational path, no clock edges.
    en = 1'b0;
    apply(32'h030391b7, 4'd4); expect_out("lui",      1'b0, 32'h03039000);
    apply(32'h030391b7, 4'd5); expect_out("auipc",    1'b0, 32'h03039000);
    apply(32'h038031ef, 4'd8); expect_out("jal",      1'b0, 32'd12344);
    apply(32'h08418063, 4'd6); expect_out("beq128",   1'b0, 32'd128);
    apply(32'h08320023, 4'd2); expect_out("sb128",    1'b0, 32'd128);
    apply(32'h08020183, 4'd0); expect_out("lb128",    1'b0, 32'd128);
    apply(32'h07b20193, 4'd1); expect_out("addi123",  1'b0, 32'd123);
    apply(32'h07b20193, 4'd7); expect_out("jalr123",  1'b0, 32'd123);
    apply(32'h005201b3, 4'd3); expect_out("reg_x",    1'b0, xval);
    apply(32'h005201b3, 4'd12); expect_out("unused_x", 1'b0, xval);
    apply(32'hfff20193, 4'd1); expect_out("addi_m1",  1'b0, 32'hFFFFFFFF);
    apply(32'hFE418EE3, 4'd6); expect_out("beq_m4",   1'b0, 32'hFFFFFFFC);
    apply(32'hFE418EE3, 4'd2); expect_out("sw_neg",   1'b0, 32'hFFFFFFFD);
    apply(32'h801001ef, 4'd8); expect_out("jal_neg",  1'b0, 32'hFFF00800);
    apply(32'hfff20193, 4'd4); expect_out("lui_top",  1'b0, 32'hFFF20000);
    apply(32'h42005013, 4'd1); expect_out("srai_raw", 1'b0, 32'h00000420);
    expect_out("q_untouched", 1'b1, 32'h0);

    // Register path.
    en = 1'b1;
    apply(32'h07b20193, 4'd1); tick();
    expect_out("q_addi", 1'b1, 32'd123);
    en = 1'b0;
    apply(32'h030391b7, 4'd4); tick();
    expect_out("q_stall", 1'b1, 32'd123);
    en = 1'b1; tick();
    expect_out("q_lui", 1'b1, 32'h03039000);
    apply(32'h005201b3, 4'd3); tick();
    expect_out("q_x_prop", 1'b1, xval);

    // Async reset between edges.
    apply(32'h07b20193, 4'd1); tick();
    expect_out("q_pre_rst", 1'b1, 32'd123);
    #2 rst_n = 1'b0;
    expect_out("q_async_rst", 1'b1, 32'h0);
    tick();
    expect_out("q_rst_hold", 1'b1, 32'h0);
    rst_n = 1'b1;

    #5;
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
